// File: rtl/change_disp_pkg.sv
// change_disp_pkg -- shared types and constants for the change dispenser.
// Holds the FSM state enum, the tube/denomination encoding and the tube limit.
package change_disp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      EJECT,
      WAIT_ACK,
      DONE
   } state_t;

   localparam logic [1:0] SEL_25C = 2'd0;
   localparam logic [1:0] SEL_10C = 2'd1;
   localparam logic [1:0] SEL_5C  = 2'd2;
   localparam logic [1:0] SEL_1C  = 2'd3;

   localparam logic [7:0] DENOM_25C = 8'd25;
   localparam logic [7:0] DENOM_10C = 8'd10;
   localparam logic [7:0] DENOM_5C  = 8'd5;
   localparam logic [7:0] DENOM_1C  = 8'd1;

   localparam logic [3:0] TUBE_MAX = 4'd15;

   // Value in cents of one coin from the given tube
   function automatic logic [7:0] denom_of(input logic [1:0] sel);
      logic [7:0] value;
      case (sel)
         SEL_25C: value = DENOM_25C;
         SEL_10C: value = DENOM_10C;
         SEL_5C:  value = DENOM_5C;
         default: value = DENOM_1C;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/change_coin_select.sv
// change_coin_select -- combinational greedy coin picker.
// Chooses the largest denomination that still fits in the remaining amount
// and whose tube holds at least one coin; valid=0 when nothing fits.
module change_coin_select
   import change_disp_pkg::*;
(
   input  logic [7:0] remaining,
   input  logic [3:0] tube_nonzero,
   output logic       valid,
   output logic [1:0] sel
);

   // Priority search from the largest coin down to the smallest
   always_comb begin
      valid = 1'b0;
      sel   = SEL_25C;
      if (tube_nonzero[SEL_25C] && (remaining >= DENOM_25C)) begin
         valid = 1'b1;
         sel   = SEL_25C;
      end else if (tube_nonzero[SEL_10C] && (remaining >= DENOM_10C)) begin
         valid = 1'b1;
         sel   = SEL_10C;
      end else if (tube_nonzero[SEL_5C] && (remaining >= DENOM_5C)) begin
         valid = 1'b1;
         sel   = SEL_5C;
      end else if (tube_nonzero[SEL_1C] && (remaining >= DENOM_1C)) begin
         valid = 1'b1;
         sel   = SEL_1C;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser -- pays out change one coin at a time from four tubes
// (25c, 10c, 5c, 1c), waiting for the mechanism to confirm each drop.
// Optional feature macro: CHANGE_DISP_TIMEOUT_EN adds a jam timeout in
// WAIT_ACK that raises fault and ends the payout with the unpaid residue.
module change_dispenser
   import change_disp_pkg::*;
#(
   parameter int TUBE_INIT   = 8,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       change_valid,
   input  logic [7:0] change_amt,
   input  logic       eject_ack,
   input  logic       refill,
   input  logic [1:0] refill_sel,
   input  logic [3:0] refill_qty,
   output logic       busy,
   output logic       coin_eject,
   output logic [1:0] coin_sel,
   output logic       done,
   output logic [7:0] shortfall,
   output logic       fault,
   output logic [3:0] tube_empty
);

   localparam logic [3:0] TUBE_INIT_L = 4'(TUBE_INIT);

   state_t     state;
   logic [7:0] remaining;
   logic [3:0] tube_cnt  [4];
   logic [3:0] tube_next [4];
   logic [3:0] tube_nonzero;
   logic [4:0] refill_sum;
   logic       pick_valid;
   logic [1:0] pick_sel;

`ifdef CHANGE_DISP_TIMEOUT_EN
   localparam logic [7:0] ACK_CNT_LIMIT = 8'(ACK_TIMEOUT - 1);
   logic [7:0] ack_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^ACK_TIMEOUT;
   assign fault = 1'b0;
`endif

   change_coin_select u_select (
      .remaining    (remaining),
      .tube_nonzero (tube_nonzero),
      .valid        (pick_valid),
      .sel          (pick_sel)
   );

   // Next tube counts: saturating refill in IDLE, one-coin decrement on ack
   always_comb begin
      refill_sum = {1'b0, tube_cnt[refill_sel]} + {1'b0, refill_qty};
      for (int i = 0; i < 4; i++) begin
         tube_next[i]    = tube_cnt[i];
         tube_nonzero[i] = (tube_cnt[i] != 4'd0);
      end
      if ((state == IDLE) && refill) begin
         tube_next[refill_sel] = (refill_sum > {1'b0, TUBE_MAX}) ? TUBE_MAX : refill_sum[3:0];
      end else if ((state == WAIT_ACK) && eject_ack) begin
         tube_next[coin_sel] = tube_cnt[coin_sel] - 4'd1;
      end
   end

   // Tube counters and their registered empty flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            tube_cnt[i]   <= TUBE_INIT_L;
            tube_empty[i] <= (TUBE_INIT_L == 4'd0);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            tube_cnt[i]   <= tube_next[i];
            tube_empty[i] <= (tube_next[i] == 4'd0);
         end
      end
   end

   // Payout FSM with registered status, eject and completion outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         coin_eject <= 1'b0;
         coin_sel   <= SEL_25C;
         done       <= 1'b0;
         shortfall  <= 8'd0;
         remaining  <= 8'd0;
`ifdef CHANGE_DISP_TIMEOUT_EN
         fault      <= 1'b0;
         ack_cnt    <= 8'd0;
`endif
      end else begin
         coin_eject <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (change_valid) begin
                  remaining <= change_amt;
                  shortfall <= 8'd0;
`ifdef CHANGE_DISP_TIMEOUT_EN
                  fault     <= 1'b0;
`endif
                  busy      <= 1'b1;
                  state     <= SELECT;
               end
            end
            SELECT: begin
               if (remaining == 8'd0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (pick_valid) begin
                  coin_sel   <= pick_sel;
                  coin_eject <= 1'b1;
                  state      <= EJECT;
               end else begin
                  shortfall <= remaining;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            EJECT: begin
`ifdef CHANGE_DISP_TIMEOUT_EN
               ack_cnt <= 8'd1;
`endif
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (eject_ack) begin
                  remaining <= remaining - denom_of(coin_sel);
                  state     <= SELECT;
`ifdef CHANGE_DISP_TIMEOUT_EN
               end else if (ack_cnt >= ACK_CNT_LIMIT) begin
                  fault     <= 1'b1;
                  shortfall <= remaining;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  ack_cnt <= ack_cnt + 8'd1;
`endif
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser -- directed self-checking bench for change_dispenser.
// Drives hand-computed payout scenarios and asserts on outputs and tube counts.
module tb_change_dispenser;

   localparam int ACK_TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       change_valid = 1'b0;
   logic [7:0] change_amt = 8'd0;
   logic       eject_ack = 1'b0;
   logic       refill = 1'b0;
   logic [1:0] refill_sel = 2'd0;
   logic [3:0] refill_qty = 4'd0;
   logic       busy;
   logic       coin_eject;
   logic [1:0] coin_sel;
   logic       done;
   logic [7:0] shortfall;
   logic       fault;
   logic [3:0] tube_empty;

   int checks = 0;
   int errors = 0;

   int         nEj;
   int         code;
   int         firstEj;
   int         doneAt;
   logic [7:0] sf;
   logic       flt;
   bit         timedOut;

   change_dispenser #(
      .TUBE_INIT   (8),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .eject_ack    (eject_ack),
      .refill       (refill),
      .refill_sel   (refill_sel),
      .refill_qty   (refill_qty),
      .busy         (busy),
      .coin_eject   (coin_eject),
      .coin_sel     (coin_sel),
      .done         (done),
      .shortfall    (shortfall),
      .fault        (fault),
      .tube_empty   (tube_empty)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case a scenario never returns
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=expired expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Tube counts packed {tube0, tube1, tube2, tube3}
   function automatic logic [15:0] tubesPacked();
      return {dut.tube_cnt[0], dut.tube_cnt[1], dut.tube_cnt[2], dut.tube_cnt[3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one change request for a single accepting cycle
   task automatic applyStimulus(input logic [7:0] amt);
      change_valid = 1'b1;
      change_amt   = amt;
      tick();
      change_valid = 1'b0;
      change_amt   = 8'd0;
   endtask

   // Follow a payout to its done pulse, acking each eject after ackDelay cycles
   // (negative ackDelay never acks); records ejects as base-4 digits in code
   task automatic serviceToDone(input int ackDelay);
      int t;
      t        = 0;
      nEj      = 0;
      code     = 0;
      firstEj  = -1;
      doneAt   = -1;
      sf       = 8'd0;
      flt      = 1'b0;
      timedOut = 1'b1;
      while (t < 400) begin
         if (coin_eject) begin
            if (firstEj < 0) firstEj = t;
            nEj++;
            code = code * 4 + int'(coin_sel);
            if (ackDelay >= 0) begin
               repeat (ackDelay) begin
                  tick();
                  t++;
               end
               eject_ack = 1'b1;
               tick();
               t++;
               eject_ack = 1'b0;
               continue;
            end
         end
         if (done) begin
            doneAt   = t;
            sf       = shortfall;
            flt      = fault;
            timedOut = 1'b0;
            break;
         end
         tick();
         t++;
      end
   endtask

   task automatic payout(input logic [7:0] amt, input int ackDelay);
      applyStimulus(amt);
      serviceToDone(ackDelay);
      tick();
   endtask

   initial begin
      $display("[TB] start");

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_eject", coin_eject, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_shortfall", shortfall, 0);
      checkOutput("rst_fault", fault, 0);
      checkOutput("rst_coin_sel", coin_sel, 0);
      checkOutput("rst_tube_empty", tube_empty, 4'h0);
      checkOutput("rst_tubes", tubesPacked(), 16'h8888);
      reset_n = 1'b1;
      tick();

      // 41c -> 25,10,5,1 with first eject two cycles after the request
      payout(8'd41, 2);
      checkOutput("p41_timeout", timedOut, 0);
      checkOutput("p41_count", nEj, 4);
      checkOutput("p41_sels", code, 32'h1B);
      checkOutput("p41_first_eject", firstEj, 1);
      checkOutput("p41_shortfall", sf, 0);
      checkOutput("p41_fault", flt, 0);
      checkOutput("p41_tubes", tubesPacked(), 16'h7777);
      checkOutput("p41_idle", busy, 0);

      // Zero amount, with a second request during busy that must be dropped
      change_valid = 1'b1;
      change_amt   = 8'd0;
      tick();
      change_amt = 8'd99;
      tick();
      change_valid = 1'b0;
      change_amt   = 8'd0;
      serviceToDone(2);
      checkOutput("p0_done", timedOut, 0);
      checkOutput("p0_count", nEj, 0);
      checkOutput("p0_shortfall", sf, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("p0_no_requeue_busy", busy, 0);
         checkOutput("p0_no_requeue_eject", coin_eject, 0);
      end

      // Drain tube 0 with 25c payouts, then 30c must come out as 10,10,10
      for (int k = 0; k < 7; k++) begin
         payout(8'd25, 2);
         checkOutput("drain25_count", nEj, 1);
         checkOutput("drain25_sel", code, 0);
      end
      checkOutput("drain25_empty", tube_empty, 4'b0001);
      payout(8'd30, 2);
      checkOutput("p30_count", nEj, 3);
      checkOutput("p30_sels", code, 32'h15);
      checkOutput("p30_shortfall", sf, 0);
      checkOutput("p30_tubes", tubesPacked(), 16'h0477);

      // Refill saturates at 15; stray ack in IDLE changes nothing
      refill     = 1'b1;
      refill_sel = 2'd1;
      refill_qty = 4'd12;
      tick();
      refill = 1'b0;
      checkOutput("refill_saturate", tubesPacked(), 16'h0F77);
      eject_ack = 1'b1;
      tick();
      eject_ack = 1'b0;
      checkOutput("idle_ack_ignored", tubesPacked(), 16'h0F77);

      // Refill while busy is ignored
      applyStimulus(8'd5);
      refill     = 1'b1;
      refill_sel = 2'd2;
      refill_qty = 4'd3;
      tick();
      refill = 1'b0;
      serviceToDone(2);
      tick();
      checkOutput("busy_refill_count", nEj, 1);
      checkOutput("busy_refill_sel", code, 2);
      checkOutput("busy_refill_tubes", tubesPacked(), 16'h0F67);

      // Reset asserted while waiting for an ack
      applyStimulus(8'd10);
      tick();
      tick();
      checkOutput("wait_ack_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("async_rst_busy", busy, 0);
      checkOutput("async_rst_tubes", tubesPacked(), 16'h8888);
      checkOutput("async_rst_eject", coin_eject, 0);
      tick();
      reset_n   = 1'b1;
      eject_ack = 1'b1;
      tick();
      eject_ack = 1'b0;
      checkOutput("late_ack_tubes", tubesPacked(), 16'h8888);
      checkOutput("late_ack_busy", busy, 0);

      // Empty every tube, then 12c cannot be paid at all
      for (int k = 0; k < 8; k++) begin
         payout(8'd41, 2);
         checkOutput("empty41_sels", code, 32'h1B);
      end
      checkOutput("all_empty", tube_empty, 4'hF);
      payout(8'd12, 2);
      checkOutput("p12_count", nEj, 0);
      checkOutput("p12_shortfall", sf, 8'd12);

      // Refill and request in the same IDLE cycle both take effect
      refill     = 1'b1;
      refill_sel = 2'd3;
      refill_qty = 4'd1;
      applyStimulus(8'd1);
      refill = 1'b0;
      serviceToDone(2);
      tick();
      checkOutput("same_cycle_count", nEj, 1);
      checkOutput("same_cycle_sel", code, 3);
      checkOutput("same_cycle_shortfall", sf, 0);
      checkOutput("same_cycle_empty", tube_empty, 4'hF);

`ifdef CHANGE_DISP_TIMEOUT_EN
      // Jam: no ack ever arrives for a 25c eject
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      payout(8'd25, -1);
      checkOutput("jam_done", timedOut, 0);
      checkOutput("jam_count", nEj, 1);
      checkOutput("jam_latency", doneAt - firstEj, ACK_TIMEOUT);
      checkOutput("jam_fault", flt, 1);
      checkOutput("jam_shortfall", sf, 8'd25);
      checkOutput("jam_tube0", tubesPacked(), 16'h8888);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
